// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone classic-cycle responder in front of an on-chip word-addressed SRAM.
// Serves one initiator port (instruction or data). The wait-state count is programmable so the
// block can model slower memories.
//
// Parameters:
//   ADDR_WIDTH  - word-address bits; the array holds 2**ADDR_WIDTH 32-bit words
//   WAIT_STATES - extra cycles before ack (0..15)
//   BASE_ADDR   - byte address of word 0, aligned to 4*2**ADDR_WIDTH
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous active-high reset
//   wb_adr_i  - byte address, bits [1:0] ignored
//   wb_dat_i  - write data
//   wb_dat_o  - read data, nonzero only during ack/err
//   wb_sel_i  - byte lane enables, sel[3] = bits [31:24] = lowest byte address
//   wb_we_i   - 1 = write, 0 = read
//   wb_cyc_i  - bus cycle active
//   wb_stb_i  - strobe
//   wb_ack_o  - single-cycle acknowledge
//   wb_err_o  - single-cycle error acknowledge
//
// Optional feature macro: WB_SRAM_ERR_EN
//   defined   - out-of-window addresses get wb_err_o, no write, wb_dat_o = 32'hDEADBEEF
//   undefined - no decode check, index wraps, wb_err_o tied to 0
module wb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Counter preload; WAIT_STATES = 0 never enters WAIT so the value is unused then.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_d;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_d;

    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_we;
    logic [3:0]            r_sel;
    logic [31:0]           r_dat;
    logic                  r_oor;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_req;
    logic [31:0]           w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_oor;
    logic                  w_in_ack;
    logic                  w_unused;

    assign w_req = wb_cyc_i & wb_stb_i;
    assign w_off = wb_adr_i - BASE_ADDR;
    assign w_idx = w_off[ADDR_WIDTH+1:2];

`ifdef WB_SRAM_ERR_EN
    // Any offset bit above the window means the access misses the array.
    assign w_oor = (w_off >> (ADDR_WIDTH + 2)) != 32'd0;
`else
    assign w_oor = 1'b0;
`endif

    // Low and high offset bits do not select a word.
    assign w_unused = ^w_off;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_state_d = ST_ACK;
                    end else begin
                        w_state_d = ST_WAIT;
                        w_cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    w_state_d = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_d = ST_ACK;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            ST_ACK:  w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Request attributes are frozen in IDLE; later bus changes are ignored.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_IDLE && w_req) begin
            r_idx <= w_idx;
            r_we  <= wb_we_i;
            r_sel <= wb_sel_i;
            r_dat <= wb_dat_i;
            r_oor <= w_oor;
        end
    end

    // With zero wait states the read happens on the sampling edge, so take the live index.
    assign w_rd_idx = (r_state == ST_IDLE) ? w_idx : r_idx;
    assign w_in_ack = (r_state == ST_ACK);

    always_ff @(posedge clk_i) begin
        if (w_state_d == ST_ACK && r_state != ST_ACK) begin
            r_rdata <= r_mem[w_rd_idx];
        end
        // Commit on the edge closing ACK; a reset on that edge abandons the write.
        if (!rst_i && w_in_ack && r_we && !r_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (r_sel[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_dat[8*i +: 8];
                end
            end
        end
    end

    assign wb_ack_o = w_in_ack & ~r_oor;
`ifdef WB_SRAM_ERR_EN
    assign wb_err_o = w_in_ack & r_oor;
`else
    assign wb_err_o = 1'b0;
`endif

    always_comb begin
        wb_dat_o = 32'd0;
        if (w_in_ack) begin
            wb_dat_o = r_oor ? 32'hDEAD_BEEF : r_rdata;
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: three instances (wait states 1, 0, 3; 16 words each) driven by
// directed and random Wishbone transfers. A word-array model predicts, per transfer, the cycle
// of the acknowledge, its kind and its data; a negedge process compares every output each cycle.
module tb_wb_sram_slave;

    localparam int NDUT = 3;
    localparam int AW   = 4;
    localparam int NW   = 16;
`ifdef WB_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s  [NDUT];
    logic [31:0] adr_s  [NDUT];
    logic [31:0] wdat_s [NDUT];
    logic [31:0] rdat_s [NDUT];
    logic [3:0]  sel_s  [NDUT];
    logic        we_s   [NDUT];
    logic        cyc_s  [NDUT];
    logic        stb_s  [NDUT];
    logic        ack_s  [NDUT];
    logic        err_s  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wb_sram_slave #(
            .ADDR_WIDTH  (AW),
            .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 0 : 3),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .clk_i    (clk),
            .rst_i    (rst_s[g]),
            .wb_adr_i (adr_s[g]),
            .wb_dat_i (wdat_s[g]),
            .wb_dat_o (rdat_s[g]),
            .wb_sel_i (sel_s[g]),
            .wb_we_i  (we_s[g]),
            .wb_cyc_i (cyc_s[g]),
            .wb_stb_i (stb_s[g]),
            .wb_ack_o (ack_s[g]),
            .wb_err_o (err_s[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    // Reference model
    logic [31:0] mdl_mem  [NDUT][NW];
    int          exp_cyc  [NDUT];
    logic [31:0] exp_dat  [NDUT];
    bit          exp_err  [NDUT];
    bit          exp_dvld [NDUT];
    int          ack_cnt  [NDUT];

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h want %h", nm, d, cyc_n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < NDUT; d++) begin
                bit in_ack;
                in_ack = (cyc_n == exp_cyc[d]);
                if (ack_s[d] === 1'b1) ack_cnt[d]++;
                chk("ack", d, 32'(ack_s[d]), 32'(in_ack && !exp_err[d]));
                chk("err", d, 32'(err_s[d]), 32'(in_ack && exp_err[d]));
                if (!in_ack) chk("dat_idle", d, rdat_s[d], 32'd0);
                else if (exp_dvld[d]) chk("dat", d, rdat_s[d], exp_dat[d]);
            end
        end
    end

    // Called and returns 1 time unit after a rising edge; leaves cyc/stb low on return.
    task automatic xfer(input int d, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rd, output logic rack, output logic rerr);
        int idx;
        bit oor;
        idx = int'((adr >> 2) & 32'(NW - 1));
        oor = ERR_EN && (adr >= 32'(4 * NW));
        exp_cyc[d]  = cyc_n + ws_of(d) + 1;
        exp_err[d]  = oor;
        exp_dat[d]  = oor ? 32'hDEAD_BEEF : mdl_mem[d][idx];
        exp_dvld[d] = oor || !we;
        cyc_s[d] = 1'b1; stb_s[d] = 1'b1; we_s[d] = we;
        adr_s[d] = adr;  wdat_s[d] = dat; sel_s[d] = sel;
        @(posedge clk) #1;
        // Bus changes after sampling must be ignored.
        adr_s[d] = $urandom; wdat_s[d] = $urandom; sel_s[d] = 4'($urandom);
        repeat (ws_of(d)) @(posedge clk) #1;
        @(negedge clk);
        rd = rdat_s[d]; rack = ack_s[d]; rerr = err_s[d];
        @(posedge clk) #1;
        if (we && !oor) begin
            for (int i = 0; i < 4; i++)
                if (sel[i]) mdl_mem[d][idx][8*i +: 8] = dat[8*i +: 8];
        end
        cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
    endtask

    // Write that the initiator abandons by dropping cyc after one wait cycle.
    task automatic abort_wr(input int d, input logic [31:0] adr, input logic [31:0] dat);
        cyc_s[d] = 1'b1; stb_s[d] = 1'b1; we_s[d] = 1'b1;
        adr_s[d] = adr;  wdat_s[d] = dat; sel_s[d] = 4'hF;
        repeat (2) @(posedge clk) #1;
        cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
        @(posedge clk) #1;
    endtask

    // Write interrupted by a one-cycle reset pulse while waiting.
    task automatic rst_wr(input int d, input logic [31:0] adr, input logic [31:0] dat);
        cyc_s[d] = 1'b1; stb_s[d] = 1'b1; we_s[d] = 1'b1;
        adr_s[d] = adr;  wdat_s[d] = dat; sel_s[d] = 4'hF;
        repeat (2) @(posedge clk) #1;
        rst_s[d] = 1'b1; cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
        @(posedge clk) #1;
        rst_s[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        rack, rerr;
    int          c0, a0;

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_s[d] = 1'b1; adr_s[d] = '0; wdat_s[d] = '0; sel_s[d] = '0;
            we_s[d] = 1'b0; cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
            exp_cyc[d] = -100; exp_err[d] = 1'b0; exp_dvld[d] = 1'b0; exp_dat[d] = '0;
            ack_cnt[d] = 0;
        end
        @(posedge clk) #1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk) #1;
        for (int d = 0; d < NDUT; d++) rst_s[d] = 1'b0;

        // Reset state and preload of every word.
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_ack", d, 32'(ack_s[d]), 32'd0);
            chk("rst_dat", d, rdat_s[d], 32'd0);
            for (int w = 0; w < NW; w++) xfer(d, 1'b1, 32'(w * 4), $urandom, 4'hF, rd, rack, rerr);
        end

        // Write then read at one wait state, then byte-lane merges.
        c0 = cyc_n;
        xfer(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, rd, rack, rerr);
        chk("wr_ack", 0, 32'(rack), 32'd1);
        chk("wr_len", 0, 32'(cyc_n - c0), 32'd3);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, rack, rerr);
        chk("rd_word", 0, rd, 32'h1234_5678);
        chk("rd_err", 0, 32'(rerr), 32'd0);
        xfer(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0100, rd, rack, rerr);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, rack, rerr);
        chk("rd_lane", 0, rd, 32'h12BB_5678);
        xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, rack, rerr);
        chk("sel0_ack", 0, 32'(rack), 32'd1);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, rack, rerr);
        chk("rd_sel0", 0, rd, 32'h12BB_5678);

        // Zero wait states, back-to-back reads.
        c0 = cyc_n; a0 = ack_cnt[1];
        for (int i = 0; i < 3; i++) xfer(1, 1'b0, 32'(i * 4), 32'h0, 4'hF, rd, rack, rerr);
        chk("b2b_acks", 1, 32'(ack_cnt[1] - a0), 32'd3);
        chk("b2b_len", 1, 32'(cyc_n - c0), 32'd6);

        // Abort keeps the prior value.
        xfer(2, 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, rd, rack, rerr);
        a0 = ack_cnt[2];
        abort_wr(2, 32'h20, 32'hFFFF_FFFF);
        chk("abort_acks", 2, 32'(ack_cnt[2] - a0), 32'd0);
        xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, rd, rack, rerr);
        chk("rd_abort", 2, rd, 32'h0BAD_F00D);

        // Reset while waiting; the next read starts straight from IDLE.
        xfer(2, 1'b1, 32'h24, 32'h600D_CAFE, 4'hF, rd, rack, rerr);
        a0 = ack_cnt[2];
        rst_wr(2, 32'h24, 32'hFFFF_FFFF);
        xfer(2, 1'b0, 32'h24, 32'h0, 4'hF, rd, rack, rerr);
        chk("rst_acks", 2, 32'(ack_cnt[2] - a0), 32'd1);
        chk("rd_rst", 2, rd, 32'h600D_CAFE);

        // Out of window read.
        xfer(0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, rack, rerr);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, rack, rerr);
        chk("oor_dat", 0, rd, ERR_EN ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
        chk("oor_ack", 0, 32'(rack), ERR_EN ? 32'd0 : 32'd1);
        chk("oor_err", 0, 32'(rerr), ERR_EN ? 32'd1 : 32'd0);

        // Random traffic with bus noise (cyc or stb alone) between transfers.
        for (int it = 0; it < 240; it++) begin
            int d;
            int gap;
            logic [31:0] adr;
            d   = $urandom_range(0, NDUT - 1);
            gap = $urandom_range(0, 2);
            for (int k = 0; k < NDUT; k++) begin
                int mode;
                mode = $urandom_range(0, 2);
                cyc_s[k] = (mode == 2);
                stb_s[k] = (mode == 1);
                adr_s[k] = $urandom;
            end
            repeat (gap) @(posedge clk) #1;
            cyc_s[d] = 1'b0; stb_s[d] = 1'b0;
            case ($urandom_range(0, 7))
                0:       adr = $urandom;
                1:       adr = 32'($urandom_range(16, 31) * 4);
                default: adr = 32'($urandom_range(0, NW - 1) * 4);
            endcase
            adr = adr | 32'($urandom_range(0, 3));
            xfer(d, 1'($urandom), adr, $urandom, 4'($urandom), rd, rack, rerr);
        end
        for (int k = 0; k < NDUT; k++) begin
            cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
        end
        repeat (4) @(posedge clk) #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
Wishbone classic-cycle responder. It fronts an on-chip word-addressed SRAM and serves either the core's instruction port or its data port. It is the target side of the core's wb_I_*/wb_D_* initiator interfaces and is instantiated once per port in the SoC top level. The wait-state count is programmable, to model slower memories for pipeline stall testing.

Parameters:
ADDR_WIDTH, 12, number of word-address bits; the array holds 2**ADDR_WIDTH 32-bit words.
WAIT_STATES, 1, extra cycles inserted before ack; legal range 0..15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2**ADDR_WIDTH.

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  reset, synchronous, active-high
wb_adr_i  in  32  byte address; bits [1:0] ignored
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data; valid only while wb_ack_o=1
wb_sel_i  in  4  byte lane enables, big-endian: sel[3]=bits[31:24]=lowest byte address
wb_we_i  in  1  1=write, 0=read
wb_cyc_i  in  1  bus cycle active
wb_stb_i  in  1  strobe
wb_ack_o  out  1  single-cycle acknowledge
wb_err_o  out  1  error acknowledge (see Optional Feature)

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, wait counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0. Memory contents are not cleared. Reset mid-transaction abandons it with no ack and no write.
- Request = wb_cyc_i & wb_stb_i. Word index = (wb_adr_i - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits.
- FSM:
  - IDLE: on request, latch adr/we/sel/dat. If WAIT_STATES=0 go to ACK, else load counter=WAIT_STATES-1 and go to WAIT.
  - WAIT: if wb_cyc_i=0, go to IDLE (abort, nothing written). If counter=0 go to ACK, else decrement the counter.
  - ACK: wb_ack_o=1 (or wb_err_o=1) for exactly one cycle, then go to IDLE.
- Latency: ack is asserted WAIT_STATES+1 cycles after the edge that samples the request. WAIT_STATES=0 gives ack on the cycle after the request.
- Reads: array is read synchronously in the cycle before ACK. wb_dat_o holds the word during ACK and returns to 0 when ack=0. sel is ignored for reads.
- Writes: committed at the clock edge that ends the ACK cycle. Only lanes with sel[i]=1 are updated; sel=4'b0000 acks with no write.
- Back-to-back: a request sampled in the cycle after ACK (IDLE) starts a new transfer, giving a minimum 2-cycle repetition at WAIT_STATES=0. A request still asserted during ACK is not re-sampled; the initiator must re-present it after seeing ack.
- Inputs are latched in IDLE. Changes to adr/dat/sel during WAIT are ignored.
- wb_ack_o and wb_err_o are never both 1. Neither is ever asserted without a preceding request.

Optional Feature:
WB_SRAM_ERR_EN
- Defined: an address outside [BASE_ADDR, BASE_ADDR+4*2**ADDR_WIDTH) follows the same FSM timing, but ACK asserts wb_err_o instead of wb_ack_o. No write occurs and wb_dat_o=32'hDEADBEEF.
- Undefined: address decode is not checked and the index wraps modulo 2**ADDR_WIDTH. wb_err_o is tied to 0.

Test Plan:
- Reset, WAIT_STATES=1: write adr=0x10, dat=0x12345678, sel=4'hF; then read 0x10 -> ack exactly 2 cycles after each request; read data 0x12345678; err=0.
- Byte lanes: over 0x12345678 at 0x10, write dat=0xAABBCCDD with sel=4'b0100 -> reading 0x10 returns 0x12BB5678.
- WAIT_STATES=0, back-to-back reads of 0x0, 0x4, 0x8 (stb re-asserted the cycle after each ack) -> one ack every 2 cycles, correct data, no extra acks.
- Abort: WAIT_STATES=3, write 0xFFFFFFFF to 0x20, drop cyc after 1 wait cycle -> no ack; reading 0x20 returns the prior value.
- Reset mid-WAIT: rst_i pulsed during WAIT -> ack never asserted; FSM in IDLE next cycle; a following read works normally.
- Out of range, ADDR_WIDTH=4, read adr=0x40: with WB_SRAM_ERR_EN -> err=1 for one cycle, data 0xDEADBEEF, ack=0; without it -> ack=1 and the data equals the word at 0x00.
